// File: rtl/fp_cmult_pkg.sv
// Shared types and defaults for the FP complex-multiplier issue/credit controller.
package fp_cmult_pkg;

  localparam int LAT_DEF   = 8;
  localparam int DEPTH_DEF = 16;
  localparam int TAGW_DEF  = 4;
  // Pipe entries carry the widest supported tag; the top zero-extends.
  localparam int TAGW_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic                last;
    logic [TAGW_MAX-1:0] tag;
  } pipe_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fp_cmult_valid_pipe.sv
// LAT-deep shadow of the multiplier array: tracks {valid, tag, last} per batch.
module fp_cmult_valid_pipe
  import fp_cmult_pkg::*;
#(
  parameter int LAT = LAT_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  pipe_t din,
  output pipe_t dout
);

  pipe_t vld_pipe [1:LAT];

  // Plain shift register; reset wipes every in-flight entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= LAT; i++) vld_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= din;
      for (int i = 2; i <= LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign dout = vld_pipe[LAT];

endmodule

// File: rtl/fp_cmult_seq.sv
// Issue/credit controller for the 64-lane FP complex multiplier array.
// Optional perf counters enabled by defining FP_CMULT_SEQ_PERF_EN.
module fp_cmult_seq
  import fp_cmult_pkg::*;
#(
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TAGW  = TAGW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush_req,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAGW-1:0]          in_tag,
  input  logic                     in_last,
  output logic                     op_load,
  output logic                     buf_wr_en,
  output logic [$clog2(DEPTH)-1:0] buf_wr_addr,
  output logic [$clog2(DEPTH)-1:0] buf_rd_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAGW-1:0]          out_tag,
  output logic                     out_last,
  output logic                     busy,
  output logic                     flush_done
`ifdef FP_CMULT_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_issued,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_bp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;   // counts 0..DEPTH inclusive

  if (LAT < 1 || DEPTH < 2 || DEPTH < LAT || !is_pow2(DEPTH) ||
      TAGW < 1 || TAGW > TAGW_MAX) begin : g_bad_cfg
    $error("fp_cmult_seq: illegal LAT/DEPTH/TAGW combination");
  end

  state_e        state;
  logic [CW-1:0] credits, inflight, occ;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TAGW-1:0] side_tag  [DEPTH];
  logic            side_last [DEPTH];

  pipe_t pin, pout;
  logic  issue, pop, wr;
  logic  tag_hi_unused;

  assign in_ready = (state == RUN) && (credits != '0);
  assign issue    = in_valid & in_ready;
  assign op_load  = issue;
  assign wr       = pout.valid;
  assign out_valid = (occ != '0);
  assign pop      = out_valid & out_ready;
  assign busy     = (inflight != '0) || (occ != '0);

  // Pack the accepted batch into a pipe entry.
  always_comb begin
    pin                = '0;
    pin.valid          = issue;
    pin.last           = in_last;
    pin.tag[TAGW-1:0]  = in_tag;
  end

  fp_cmult_valid_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (pin),
    .dout  (pout)
  );

  assign tag_hi_unused = ^pout.tag;

  assign buf_wr_en   = wr;
  assign buf_wr_addr = wr_ptr;
  assign buf_rd_addr = rd_ptr;
  // Gate with out_valid so an empty buffer presents zeros, never stale slots.
  assign out_tag     = out_valid ? side_tag[rd_ptr]  : '0;
  assign out_last    = out_valid ? side_last[rd_ptr] : 1'b0;

  // Control FSM; flush_done is a registered pulse on DRAIN->IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE:  if (start) state <= RUN;
        RUN:   if (flush_req) state <= DRAIN;
        DRAIN: if (inflight == '0 && occ == '0) begin
                 state      <= IDLE;
                 flush_done <= 1'b1;
               end
        default: state <= IDLE;
      endcase
    end
  end

  // Credit, occupancy and pointer bookkeeping; credits == DEPTH - inflight - occ.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits  <= CW'(DEPTH);
      inflight <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      credits  <= credits  - CW'(issue) + CW'(pop);
      inflight <= inflight + CW'(issue) - CW'(wr);
      occ      <= occ      + CW'(wr)    - CW'(pop);
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Side array holds tag/last for each RAM slot; contents only matter while occupied.
  always_ff @(posedge clk) begin
    if (wr) begin
      side_tag[wr_ptr]  <= pout.tag[TAGW-1:0];
      side_last[wr_ptr] <= pout.last;
    end
  end

`ifdef FP_CMULT_SEQ_PERF_EN
  // Saturating perf counters, restarted on every IDLE->RUN.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && start)) begin
      perf_issued <= '0;
      perf_stall  <= '0;
      perf_bp     <= '0;
    end else begin
      if (issue && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (state == RUN && in_valid && !in_ready && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
      if (out_valid && !out_ready && perf_bp != '1) perf_bp <= perf_bp + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_cmult_seq.sv
// Scoreboard bench for fp_cmult_seq (LAT=8, DEPTH=16, TAGW=4).
module tb_fp_cmult_seq;

  localparam int LAT = 8, DEPTH = 16, TAGW = 4, AW = 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush_req = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic in_ready, op_load, buf_wr_en, out_valid, out_last, busy, flush_done;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [TAGW-1:0] out_tag;
`ifdef FP_CMULT_SEQ_PERF_EN
  logic [31:0] perf_issued, perf_stall, perf_bp;
`endif

  fp_cmult_seq #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .start(start), .flush_req(flush_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_last(in_last),
    .op_load(op_load), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_rd_addr(buf_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_last(out_last), .busy(busy), .flush_done(flush_done)
`ifdef FP_CMULT_SEQ_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall), .perf_bp(perf_bp)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  logic [TAGW:0] sb [$];
  int exp_wr = 0, exp_rd = 0;
  int n_iss = 0, n_wr = 0, n_pop = 0, n_fd = 0;
  int t_iss = -1, t_wr = -1, t_ov = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: push on issue, check write slots, pop and compare on consume.
  always @(negedge clk) begin
    logic [TAGW:0] e;
    if (reset) begin
      sb.delete();
      exp_wr = 0;
      exp_rd = 0;
    end else begin
      chk("op_load", op_load, in_valid && in_ready);
      if (in_valid && in_ready) begin
        sb.push_back({in_last, in_tag});
        n_iss++;
        t_iss = cyc;
      end
      if (buf_wr_en) begin
        chk("wr_addr", buf_wr_addr, exp_wr % DEPTH);
        exp_wr++;
        n_wr++;
        if (t_wr < 0) t_wr = cyc;
      end
      if (out_valid && t_ov < 0) t_ov = cyc;
      if (out_valid && out_ready) begin
        chk("rd_addr", buf_rd_addr, exp_rd % DEPTH);
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_tag", out_tag, e[TAGW-1:0]);
          chk("out_last", out_last, e[TAGW]);
        end
        exp_rd++;
        n_pop++;
      end
      if (flush_done) n_fd++;
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); #1; endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    smp();
    while (busy && k < 200) begin smp(); k++; end
    chk(tag, k < 200, 1);
  endtask

  initial begin
    int k, b_iss, b_pop, b_wr, b_fd, ir_low;

    // Reset state
    repeat (3) step();
    reset = 1'b0;
    step(); smp();
    chk("rst_in_ready", in_ready, 0);   chk("rst_op_load", op_load, 0);
    chk("rst_wr_en", buf_wr_en, 0);     chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_rd_addr", buf_rd_addr, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_tag", out_tag, 0);     chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);           chk("rst_flush_done", flush_done, 0);

    // Single batch latency
    step(); start = 1'b1;
    step(); start = 1'b0; in_valid = 1'b1; in_tag = 4'd3; in_last = 1'b1;
    smp(); chk("s1_in_ready", in_ready, 1);
    step(); in_valid = 1'b0; in_tag = '0; in_last = 1'b0;
    k = 0; smp();
    while (!out_valid && k < 30) begin smp(); k++; end
    chk("s1_timeout", k < 30, 1);
    chk("s1_tag", out_tag, 3); chk("s1_last", out_last, 1); chk("s1_busy", busy, 1);
    step();
    chk("s1_lat_wr", t_wr - t_iss, LAT);
    chk("s1_lat_ov", t_ov - t_iss, LAT + 1);
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    smp(); chk("s1_busy_after_pop", busy, 0);

    // Back-pressure: fill all credits, one pop frees one slot
    b_iss = n_iss; b_pop = n_pop;
    for (int i = 0; i < 30; i++) begin
      step(); in_valid = 1'b1; in_tag = TAGW'(i); in_last = i[0];
    end
    smp();
    chk("bp_accepted", n_iss - b_iss, 16);
    chk("bp_ready_low", in_ready, 0);
    step(); out_ready = 1'b1;
    smp(); chk("bp_ready_popcyc", in_ready, 0);
    step(); out_ready = 1'b0;
    smp(); chk("bp_ready_back", in_ready, 1);
    step();
    smp(); chk("bp_ready_again", in_ready, 0);
    step(); in_valid = 1'b0; out_ready = 1'b1;
    drain("bp_drain_timeout");
    chk("bp_total_iss", n_iss - b_iss, 17);
    chk("bp_total_pop", n_pop - b_pop, 17);

    // Streaming with out_ready=1
    step(); b_iss = n_iss; b_pop = n_pop; ir_low = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_tag = TAGW'($urandom); in_last = 1'($urandom);
      smp();
      if (!in_ready) ir_low++;
      step();
    end
    in_valid = 1'b0;
    drain("st_drain_timeout");
    chk("st_ready_low_cycles", ir_low, 0);
    chk("st_iss", n_iss - b_iss, 100);
    chk("st_pop", n_pop - b_pop, 100);

    // Flush with 5 in flight and 3 buffered
    step(); out_ready = 1'b0; b_wr = n_wr; b_pop = n_pop;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_tag = TAGW'(i + 5); in_last = (i == 7);
      step();
    end
    in_valid = 1'b0;
    k = 0; smp();
    while (n_wr - b_wr < 3 && k < 30) begin smp(); k++; end
    chk("fl_wr_timeout", k < 30, 1);
    step(); flush_req = 1'b1;
    step(); flush_req = 1'b0; in_valid = 1'b1; b_iss = n_iss;
    smp(); chk("fl_ready_low", in_ready, 0);
    step(); out_ready = 1'b1; b_fd = n_fd;
    k = 0; smp();
    while (!flush_done && k < 60) begin smp(); k++; end
    chk("fl_done_timeout", k < 60, 1);
    chk("fl_pops", n_pop - b_pop, 8);
    repeat (5) step();
    smp();
    chk("fl_done_once", n_fd - b_fd, 1);
    chk("fl_no_issue", n_iss - b_iss, 0);
    chk("fl_idle_ready", in_ready, 0);
    chk("fl_idle_busy", busy, 0);

    // Reset with 4 in flight
    step(); in_valid = 1'b0; out_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0; in_valid = 1'b1; b_iss = n_iss;
    repeat (4) step();
    in_valid = 1'b0; reset = 1'b1;
    step(); reset = 1'b0; b_wr = n_wr;
    chk("rs_issued", n_iss - b_iss, 4);
    smp();
    chk("rs_in_ready", in_ready, 0);   chk("rs_wr_en", buf_wr_en, 0);
    chk("rs_wr_addr", buf_wr_addr, 0); chk("rs_rd_addr", buf_rd_addr, 0);
    chk("rs_out_valid", out_valid, 0); chk("rs_out_tag", out_tag, 0);
    chk("rs_out_last", out_last, 0);   chk("rs_busy", busy, 0);
    chk("rs_flush_done", flush_done, 0);
    repeat (15) step();
    smp(); chk("rs_no_wr", n_wr - b_wr, 0);

    // Credits back to DEPTH after reset (and perf counters when enabled)
    step(); start = 1'b1;
    step(); start = 1'b0; in_valid = 1'b1; b_iss = n_iss;
    repeat (20) step();
    in_valid = 1'b0;
    smp();
    chk("cr_accepted", n_iss - b_iss, 16);
`ifdef FP_CMULT_SEQ_PERF_EN
    chk("perf_issued", perf_issued, 16);
    chk("perf_stall", perf_stall, 4);
    chk("perf_bp", perf_bp, 11);
`endif
    step(); out_ready = 1'b1;
    drain("cr_drain_timeout");
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
